instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Front-end fetch stage that sits directly upstream of the register file, ALU and control datapath. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned instructions, tagged with their PC, are buffered in a small prefetch FIFO. Decode consumes them through a valid/ready interface, and a redirect input from branch/jump resolution flushes the buffer and restarts fetch.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, fetch address after reset; word aligned
ADDR_W, 32, address and PC width

Ports:
clk  input  1  clock; all state updates on rising edge
clr_n  input  1  asynchronous, active-low reset
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address; bits [1:0] ignored and forced to 0
imem_req  output  1  instruction memory request, registered
imem_addr  output  ADDR_W  request address, registered
imem_ack  input  1  memory accepted request and imem_rdata is valid this cycle
imem_rdata  input  32  instruction word
instr_valid  output  1  FIFO head holds an instruction
instr  output  32  instruction at FIFO head
instr_pc  output  ADDR_W  PC of instruction at FIFO head
instr_ready  input  1  decode accepts head; pop when instr_valid & instr_ready

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (clr_n).
- Reset (clr_n=0, async):
  - FSM=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0.
  - instr and instr_pc read 0 while the FIFO is empty.
  - Assertion mid-transaction abandons any outstanding request without waiting for imem_ack.
- FSM states:
  - IDLE: no request outstanding. If count < DEPTH and no redirect, go to REQ and drive imem_req=1, imem_addr=fetch_pc.
  - REQ: imem_req=1. imem_addr is held stable until imem_ack. On ack, push {fetch_pc, imem_rdata} and set fetch_pc += 4. Then stay in REQ with the next address if count_after_push < DEPTH; otherwise go to IDLE with imem_req=0.
  - DRAIN: a redirect arrived while a request was outstanding. imem_req and imem_addr stay held. The ack data is discarded, then the next state is REQ at the redirected fetch_pc.
- Space rule: a request is issued only if count (after this cycle's push/pop) < DEPTH. The outstanding request always has a reserved slot, so the FIFO never overflows and no ack is ever dropped for lack of space.
- Throughput and latency:
  - With zero-wait memory (ack in the same cycle as req), one instruction per cycle.
  - Ack at edge N gives instr_valid=1 after edge N; the FIFO head drives the outputs combinationally.
  - The first imem_req=1 is seen one cycle after clr_n deassertion.
- Redirect (highest priority):
  - Flushes the FIFO; instr_valid=0 the next cycle, and any simultaneous pop is ignored.
  - Sets fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - From IDLE, or from REQ with ack in the same cycle: ack data is discarded, next state is REQ at the new address.
  - From REQ without ack: next state is DRAIN.
  - From DRAIN: updates the target address; still drains.
- Simultaneous push and pop: both happen; count is unchanged.
- Wrap-around: fetch_pc increments modulo 2^ADDR_W. FIFO pointers wrap naturally at DEPTH.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs stat_fetched (32, counts instr_valid & instr_ready pops) and stat_flushes (32, counts redirect cycles). Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then release, zero-wait memory, instr_ready=1 → imem_addr sequence 0x0,0x4,0x8,...; instr_pc/instr follow one cycle behind the acks, one instruction per cycle.
- instr_ready=0, zero-wait memory, DEPTH=4 → exactly 4 acks; imem_req falls to 0 and instr_pc at head=0x0. Then instr_ready=1 for 1 cycle → one pop, then imem_req=1 with imem_addr=0x10.
- Memory acks 3 cycles after req, redirect to 0x103 asserted in the 1st wait cycle → imem_addr held until ack, ack data dropped, next request addr=0x100, FIFO empty throughout.
- Redirect to 0x200 in the same cycle as an ack for 0x8 → word for 0x8 never appears; next imem_addr=0x200; instr_valid=0 the following cycle.
- FIFO full, redirect and pop in the same cycle → FIFO empty next cycle (pop ignored); with FETCH_STATS_EN, stat_flushes increments by 1 and stat_fetched is unchanged.
- clr_n pulsed low while imem_req=1 awaiting ack → imem_req=0, instr_valid=0 immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// Owns the fetch PC and issues word requests to instruction memory over a
// req/ack handshake. Each returned word is buffered with its PC in a small
// prefetch FIFO. Decode drains the FIFO through instr_valid/instr_ready.
// A redirect flushes the buffer and restarts fetch at a new word-aligned
// address.
// Optional feature: define FETCH_STATS_EN to add the stat_fetched and
// stat_flushes counter outputs.
module instruction_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushes
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] pc_inc;

  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;

  // The low address bits of a redirect are ignored; keep them visibly unused.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc    = fetch_pc + ADDR_W'(4);

  // FIFO head drives decode directly; outputs read zero while empty.
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

  // A redirect kills both the pending push and any pop in the same cycle.
  assign push      = (state == S_REQ) && imem_ack && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Next-state logic: issue only when a slot is free after this cycle's
  // push/pop, so every outstanding request always owns a FIFO slot.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    case (state)
      S_IDLE: begin
        if (redirect) begin
          state_nxt    = S_REQ;
          fetch_pc_nxt = target_pc;
          req_nxt      = 1'b1;
          addr_nxt     = target_pc;
        end else if (count_nxt < FULL_CNT) begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
        end
      end
      S_REQ: begin
        if (redirect) begin
          fetch_pc_nxt = target_pc;
          if (imem_ack) begin
            state_nxt = S_REQ;
            req_nxt   = 1'b1;
            addr_nxt  = target_pc;
          end else begin
            state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          fetch_pc_nxt = pc_inc;
          if (count_nxt < FULL_CNT) begin
            req_nxt  = 1'b1;
            addr_nxt = pc_inc;
          end else begin
            state_nxt = S_IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          fetch_pc_nxt = target_pc;
        end
        if (imem_ack) begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = redirect ? target_pc : fetch_pc;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // FSM, fetch PC and registered memory request outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // FIFO storage: each entry pairs the returned word with its fetch PC.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef FETCH_STATS_EN
  // Free-running counters of delivered instructions and redirect cycles.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (pop) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (redirect) begin
        stat_flushes <= stat_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// A behavioural memory answers requests after a programmable latency, a
// reference FIFO (scoreboard queue) is filled on every accepted ack and
// drained on every pop, and the FIFO head is compared on each falling edge.
// Directed sequences check addresses, full/stall, redirect and reset cases.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0]       stat_fetched;
  logic [31:0]       stat_flushes;
  logic [31:0]       exp_fetched;
  logic [31:0]       exp_flushes;
`endif

  int          errors = 0;
  int          checks = 0;
  int          latency = 0;
  int          wait_cnt = 0;
  int          ack_count = 0;
  logic        req_seen = 1'b0;
  logic [31:0] ack_addr = '0;
  bit          drain = 1'b0;
  bit          mon_en = 1'b0;
  bit          track8 = 1'b0;
  bit          saw_pc8 = 1'b0;
  entry_t      sb_q[$];

  instruction_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushes(stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Hold reset for two cycles, check reset outputs, release on a falling edge.
  task automatic applyReset(input bit rdy);
    clr_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = rdy;
    repeat (2) @(negedge clk);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_pc", instr_pc, 32'h0);
    clr_n = 1'b1;
  endtask

  // Drive redirect / ready for the coming rising edge.
  task automatic applyStimulus(input bit rdy, input bit rd, input logic [31:0] pc);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = pc;
  endtask

  // Memory responder: acks a request after 'latency' wait cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      req_seen = imem_req;
      if (!clr_n || !imem_req) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= latency) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        ack_addr   = imem_addr;
        wait_cnt   = 0;
        ack_count++;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Reference FIFO update on each rising edge from the bench-driven inputs.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      if (!clr_n) begin
        sb_q.delete();
        drain = 1'b0;
`ifdef FETCH_STATS_EN
        exp_fetched = '0;
        exp_flushes = '0;
`endif
      end else if (redirect) begin
        sb_q.delete();
        drain = req_seen && !imem_ack;
`ifdef FETCH_STATS_EN
        exp_flushes = exp_flushes + 32'd1;
`endif
      end else begin
        if (sb_q.size() != 0 && instr_ready) begin
          void'(sb_q.pop_front());
`ifdef FETCH_STATS_EN
          exp_fetched = exp_fetched + 32'd1;
`endif
        end
        if (imem_ack) begin
          if (drain) begin
            drain = 1'b0;
          end else begin
            e.pc   = ack_addr;
            e.data = memWord(ack_addr);
            sb_q.push_back(e);
          end
        end
      end
    end
  end

  // Asynchronous reset empties the reference FIFO immediately.
  initial begin
    forever begin
      @(negedge clr_n);
      sb_q.delete();
      drain = 1'b0;
    end
  end

  // Compare the FIFO head against the reference on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("head_valid", instr_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
          checkOutput("head_pc", instr_pc, sb_q[0].pc);
          checkOutput("head_instr", instr, sb_q[0].data);
        end else begin
          checkOutput("empty_pc", instr_pc, 32'h0);
          checkOutput("empty_instr", instr, 32'h0);
        end
`ifdef FETCH_STATS_EN
        checkOutput("stat_fetched", stat_fetched, exp_fetched);
        checkOutput("stat_flushes", stat_flushes, exp_flushes);
`endif
        if (track8 && instr_valid && instr_pc == 32'h8) begin
          saw_pc8 = 1'b1;
        end
      end
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences.
  initial begin
    int guard;
    clr_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mon_en      = 1'b1;

    // Streaming fetch with zero-wait memory.
    latency = 0;
    applyReset(1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("t1_req", imem_req, 1'b1);
      checkOutput("t1_addr", imem_addr, 32'(4 * i));
    end

    // Decode stalled: FIFO fills after exactly DEPTH acks, then one pop.
    latency = 0;
    applyReset(1'b0);
    ack_count = 0;
    repeat (10) @(negedge clk);
    checkOutput("t2_acks", ack_count, DEPTH);
    checkOutput("t2_req_idle", imem_req, 1'b0);
    checkOutput("t2_head_pc", instr_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_req_again", imem_req, 1'b1);
    checkOutput("t2_addr_again", imem_addr, 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (6) @(negedge clk);

    // Redirect while a slow request is outstanding.
    latency = 3;
    applyReset(1'b1);
    @(negedge clk);
    checkOutput("t3_req", imem_req, 1'b1);
    checkOutput("t3_addr0", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h103);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_hold1", imem_addr, 32'h0);
    checkOutput("t3_hold_req", imem_req, 1'b1);
    @(negedge clk);
    checkOutput("t3_hold2", imem_addr, 32'h0);
    @(negedge clk);
    checkOutput("t3_hold3", imem_addr, 32'h0);
    @(negedge clk);
    checkOutput("t3_new_req", imem_req, 1'b1);
    checkOutput("t3_new_addr", imem_addr, 32'h100);
    guard = 0;
    while (!instr_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t3_data_arrives", guard < 20, 1'b1);
    checkOutput("t3_first_pc", instr_pc, 32'h100);

    // Redirect coinciding with the ack for 0x8.
    latency = 0;
    applyReset(1'b1);
    saw_pc8 = 1'b0;
    track8  = 1'b1;
    guard   = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (imem_addr != 32'h8 && guard < 20);
    checkOutput("t4_reach_8", guard < 20, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h200);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_addr", imem_addr, 32'h200);
    checkOutput("t4_valid", instr_valid, 1'b0);
    repeat (5) @(negedge clk);
    track8 = 1'b0;
    checkOutput("t4_no_pc8", saw_pc8, 1'b0);

    // Full FIFO, redirect and pop in the same cycle.
    latency = 0;
    applyReset(1'b0);
    repeat (8) @(negedge clk);
    checkOutput("t5_full_req", imem_req, 1'b0);
    checkOutput("t5_full_valid", instr_valid, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h300);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t5_flushed", instr_valid, 1'b0);
    checkOutput("t5_addr", imem_addr, 32'h300);
`ifdef FETCH_STATS_EN
    checkOutput("t5_flushes", stat_flushes, 32'd1);
    checkOutput("t5_fetched", stat_fetched, 32'd0);
`endif
    repeat (4) @(negedge clk);

    // Asynchronous reset while a request is waiting for its ack.
    latency = 0;
    applyReset(1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 latency = 5;
    @(negedge clk);
    checkOutput("t6_req_pending", imem_req, 1'b1);
    checkOutput("t6_valid_before", instr_valid, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("t6_req_async", imem_req, 1'b0);
    checkOutput("t6_valid_async", instr_valid, 1'b0);
    checkOutput("t6_addr_async", imem_addr, RESET_PC);
    latency = 0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_restart_req", imem_req, 1'b1);
    checkOutput("t6_restart_addr", imem_addr, RESET_PC);
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (6) @(negedge clk);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
